cram_ldst_port: RTL and testbench

- Memory-side port of the retiming element's compressed RAM (CRAM).
- Sits directly downstream of the load/store unit. It consumes that unit's load and store requests (Req/Mode/Address, store data token), owns a single-port SRAM array, and returns load data as a forward token.
- Loads are always accepted. Stores are back-pressured on collision. A skid FIFO absorbs in-flight reads while the consumer nacks.

---
 rtl/cram_ldst_port_pkg.sv | 34 +++
 rtl/cram_ldst_port_skid.sv | 42 ++++
 rtl/cram_ldst_port.sv | 84 ++++++++
 tb/tb_cram_ldst_port.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/cram_ldst_port_pkg.sv
// cram_ldst_port_pkg: token types (pkg_en) and CRAM access-mode helpers (pkg_mem)
package pkg_en;
  localparam int WIDTH_TOKEN = 32;
  typedef struct packed {
`ifdef EXTEND
    logic i;
`endif
    logic v;
    logic a;
    logic c;
    logic r;
    logic [WIDTH_TOKEN-1:0] d;
  } FTk_t;
  typedef struct packed {
    logic n;
  } BTk_t;
endpackage

package pkg_mem;
  localparam int MEM_WIDTH_DATA = 32;
  localparam int MEM_WIDTH_UNIT = 8;
  localparam int DEPTH_SKID_CRAM = 2;
  typedef enum logic [1:0] {
    MODE_WORD = 2'b00,
    MODE_HALF = 2'b01,
    MODE_UNIT = 2'b10
  } mode_t;
  // Low-lane mask selected by an access mode; 2'b11 falls through to full word.
  function automatic logic [MEM_WIDTH_DATA-1:0] lane_mask(input logic [1:0] mode);
    return mode == MODE_HALF ? {{(MEM_WIDTH_DATA/2){1'b0}}, {(MEM_WIDTH_DATA/2){1'b1}}} :
           mode == MODE_UNIT ? {{(MEM_WIDTH_DATA-MEM_WIDTH_UNIT){1'b0}}, {MEM_WIDTH_UNIT{1'b1}}} :
           {MEM_WIDTH_DATA{1'b1}};
  endfunction
endpackage

// File: rtl/cram_ldst_port_skid.sv
// cram_ld_skid: load-return skid FIFO of forward tokens; push and pop may coincide
module cram_ld_skid
  import pkg_en::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  FTk_t                       din,
  output FTk_t                       dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  FTk_t slots [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  always_comb begin
    empty = count == '0;
    full = count == CW'(DEPTH);
    do_pop = pop & ~empty;
    do_push = push & (~full | do_pop);
    dout = slots[rp];
  end
  always_ff @(posedge clock)
    if (do_push) slots[wp] <= din;
  always_ff @(posedge clock) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp == AW'(DEPTH-1) ? '0 : wp + AW'(1);
      if (do_pop) rp <= rp == AW'(DEPTH-1) ? '0 : rp + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/cram_ldst_port.sv
// cram_ldst_port: single-port CRAM behind the load/store unit with a load-return skid FIFO.
// Define CRAM_LDST_FWD_EN to forward a colliding store's lanes into the same-cycle load.
module cram_ldst_port
  import pkg_en::*;
  import pkg_mem::*;
#(
  parameter int WIDTH_DATA = 32,
  parameter int WIDTH_ADDR = 10,
  parameter int WIDTH_UNIT = 8,
  parameter int SIZE_CRAM  = 256,
  parameter int DEPTH_SKID = DEPTH_SKID_CRAM
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  I_Ld_Req,
  input  logic [1:0]            I_Ld_Mode,
  input  logic [WIDTH_ADDR-1:0] I_Ld_Address,
  output FTk_t                  O_Ld_Data,
  input  BTk_t                  I_Ld_BTk,
  input  logic                  I_St_Req,
  input  logic [1:0]            I_St_Mode,
  input  logic [WIDTH_ADDR-1:0] I_St_Address,
  input  FTk_t                  I_St_Data,
  output BTk_t                  O_St_BTk,
  output logic                  O_Busy,
  output logic                  O_Ld_Ovf
);
  localparam int IW = $clog2(SIZE_CRAM);
  localparam logic [WIDTH_ADDR:0] LIMIT = (WIDTH_ADDR+1)'(SIZE_CRAM);
  logic [WIDTH_DATA-1:0] sram [SIZE_CRAM];
  logic [WIDTH_DATA-1:0] st_mask, st_merge, rd_word, fresh_d;
  logic ld_ok, st_ok, st_we, fwd, fresh_v, push, pop, full, empty, ovf, unused;
  logic [$clog2(DEPTH_SKID+1)-1:0] count;
  FTk_t fresh_tok, head;
  always_comb begin
    ld_ok = {1'b0, I_Ld_Address} < LIMIT;
    st_ok = {1'b0, I_St_Address} < LIMIT;
    st_we = I_St_Req & ~I_Ld_Req & st_ok;
    st_mask = lane_mask(I_St_Mode);
    st_merge = (sram[I_St_Address[IW-1:0]] & ~st_mask) | (I_St_Data.d & st_mask);
`ifdef CRAM_LDST_FWD_EN
    fwd = I_St_Req & st_ok & (I_St_Address == I_Ld_Address);
`else
    fwd = 1'b0;
`endif
    rd_word = fwd ? st_merge : sram[I_Ld_Address[IW-1:0]];
    fresh_tok = '0;
    fresh_tok.v = fresh_v;
    fresh_tok.d = fresh_d;
    // A nacked fresh word must be parked even though it is shown this cycle.
    push = fresh_v & (~empty | I_Ld_BTk.n);
    pop = ~empty & ~I_Ld_BTk.n;
    O_Ld_Data = ~empty ? head : fresh_v ? fresh_tok : '0;
    O_St_BTk = '0;
    O_St_BTk.n = I_St_Req & I_Ld_Req;
    O_Busy = fresh_v | (count != '0);
    O_Ld_Ovf = ovf;
    unused = ^I_St_Data;
  end
  always_ff @(posedge clock)
    if (st_we) sram[I_St_Address[IW-1:0]] <= st_merge;
  always_ff @(posedge clock) begin
    if (reset) begin
      fresh_v <= 1'b0;
      fresh_d <= '0;
      ovf <= 1'b0;
    end else begin
      fresh_v <= I_Ld_Req;
      fresh_d <= ld_ok ? rd_word & lane_mask(I_Ld_Mode) : '0;
      ovf <= ovf | (push & full & ~pop);
    end
  end
  cram_ld_skid #(.DEPTH(DEPTH_SKID)) u_skid (
    .clock(clock),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din(fresh_tok),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
endmodule

// File: tb/tb_cram_ldst_port.sv
// tb_cram_ldst_port: scoreboard bench for the CRAM load/store port
module tb_cram_ldst_port;
  import pkg_en::*;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  logic ld_req, st_req, busy, ovf;
  logic [1:0] ld_mode, st_mode;
  logic [9:0] ld_addr, st_addr;
  FTk_t ld_data, st_data;
  BTk_t ld_btk, st_btk;
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];

  cram_ldst_port dut (
    .clock(clock), .reset(reset),
    .I_Ld_Req(ld_req), .I_Ld_Mode(ld_mode), .I_Ld_Address(ld_addr),
    .O_Ld_Data(ld_data), .I_Ld_BTk(ld_btk),
    .I_St_Req(st_req), .I_St_Mode(st_mode), .I_St_Address(st_addr),
    .I_St_Data(st_data), .O_St_BTk(st_btk),
    .O_Busy(busy), .O_Ld_Ovf(ovf)
  );

  task automatic drv(input logic lr, input logic [1:0] lm, input logic [9:0] la, input logic n,
                     input logic sr, input logic [1:0] sm, input logic [9:0] sa, input logic [31:0] sd);
    ld_req = lr; ld_mode = lm; ld_addr = la; ld_btk.n = n;
    st_req = sr; st_mode = sm; st_addr = sa;
    st_data = '0; st_data.v = sr; st_data.d = sd;
    #1;
  endtask

  // Every accepted delivery is matched against the oldest expected word.
  task automatic adv();
    if (ld_data.v && !ld_btk.n) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got d=%h, required no delivery", ld_data.d);
      end else begin
        logic [31:0] e = exp_q.pop_front();
        if (ld_data.d !== e) begin
          errors++;
          $display("FAIL sb_data: got %h, required %h", ld_data.d, e);
        end
      end
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clock);
    #1;
    checks++; if (ld_data !== '0) begin errors++; $display("FAIL rst_ld_data: got %h, required 0", ld_data); end
    checks++; if (st_btk.n !== 1'b0) begin errors++; $display("FAIL rst_st_btk: got %b, required 0", st_btk.n); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b, required 0", ovf); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_store_load();
    drv(0, 0, 0, 0, 1, 2'b00, 5, 32'hDEADBEEF);
    checks++; if (st_btk.n !== 1'b0) begin errors++; $display("FAIL st_ack: got %b, required 0", st_btk.n); end
    adv();
    drv(1, 2'b00, 5, 0, 0, 0, 0, 0);
    exp_q.push_back(32'hDEADBEEF);
    checks++; if (ld_data.v !== 1'b0) begin errors++; $display("FAIL ld_early: got v=%b, required 0", ld_data.v); end
    adv();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (ld_data.v !== 1'b1 || ld_data.d !== 32'hDEADBEEF) begin
      errors++; $display("FAIL ld_latency: got v=%b d=%h, required v=1 d=deadbeef", ld_data.v, ld_data.d);
    end
    adv();
  endtask

  task automatic test_lanes();
    drv(0, 0, 0, 0, 1, 2'b10, 5, 32'h123456AA);
    adv();
    drv(1, 2'b00, 5, 0, 0, 0, 0, 0); exp_q.push_back(32'hDEADBEAA); adv();
    drv(1, 2'b01, 5, 0, 0, 0, 0, 0); exp_q.push_back(32'h0000BEAA); adv();
    drv(1, 2'b10, 5, 0, 0, 0, 0, 0); exp_q.push_back(32'h000000AA); adv();
    drv(1, 2'b11, 5, 0, 0, 0, 0, 0); exp_q.push_back(32'hDEADBEAA); adv();
    drv(0, 0, 0, 0, 0, 0, 0, 0); adv();
  endtask

  task automatic test_collision();
    drv(1, 2'b00, 5, 0, 1, 2'b00, 5, 32'h11111111);
    checks++; if (st_btk.n !== 1'b1) begin errors++; $display("FAIL coll_nack: got %b, required 1", st_btk.n); end
`ifdef CRAM_LDST_FWD_EN
    exp_q.push_back(32'h11111111);
`else
    exp_q.push_back(32'hDEADBEAA);
`endif
    adv();
    drv(0, 0, 0, 0, 1, 2'b00, 5, 32'h11111111);
    checks++; if (st_btk.n !== 1'b0) begin errors++; $display("FAIL coll_retry_ack: got %b, required 0", st_btk.n); end
    adv();
    drv(1, 2'b00, 5, 0, 0, 0, 0, 0); exp_q.push_back(32'h11111111); adv();
    drv(0, 0, 0, 0, 0, 0, 0, 0); adv();
  endtask

  task automatic test_back_to_back();
    for (int k = 1; k <= 4; k++) begin
      drv(0, 0, 0, 0, 1, 2'b00, 10'(k), 32'hA0000000 + k);
      adv();
    end
    drv(1, 2'b00, 1, 0, 0, 0, 0, 0); exp_q.push_back(32'hA0000001); adv();
    drv(1, 2'b00, 2, 1, 0, 0, 0, 0); exp_q.push_back(32'hA0000002);
    checks++;
    if (ld_data.v !== 1'b1 || ld_data.d !== 32'hA0000001) begin
      errors++; $display("FAIL b2b_shown: got v=%b d=%h, required v=1 d=a0000001", ld_data.v, ld_data.d);
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy1: got %b, required 1", busy); end
    adv();
    drv(1, 2'b00, 3, 1, 0, 0, 0, 0); exp_q.push_back(32'hA0000003);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy2: got %b, required 1", busy); end
    adv();
    repeat (3) begin drv(0, 0, 0, 0, 0, 0, 0, 0); adv(); end
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got busy=%b, required 0", busy); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL b2b_ovf: got %b, required 0", ovf); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain: got %0d pending, required 0", exp_q.size()); end
    adv();
  endtask

  task automatic test_overflow();
    for (int k = 1; k <= 4; k++) begin
      drv(1, 2'b00, 10'(k), 1, 0, 0, 0, 0);
      adv();
    end
    drv(0, 0, 0, 1, 0, 0, 0, 0);
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b, required 1", ovf); end
    checks++;
    if (ld_data.v !== 1'b1 || ld_data.d !== 32'hA0000001) begin
      errors++; $display("FAIL ovf_head: got v=%b d=%h, required v=1 d=a0000001", ld_data.v, ld_data.d);
    end
    adv();
    drv(0, 0, 0, 1, 0, 0, 0, 0);
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b, required 1", ovf); end
    adv();
    reset = 1'b1;
    drv(0, 0, 0, 1, 0, 0, 0, 0);
    adv();
    reset = 1'b0;
    drv(0, 0, 0, 1, 0, 0, 0, 0);
    checks++; if (ld_data.v !== 1'b0) begin errors++; $display("FAIL ovf_rst_v: got %b, required 0", ld_data.v); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovf_rst_busy: got %b, required 0", busy); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_rst_clr: got %b, required 0", ovf); end
    adv();
    drv(1, 2'b00, 2, 0, 0, 0, 0, 0); exp_q.push_back(32'hA0000002); adv();
    drv(0, 0, 0, 0, 0, 0, 0, 0); adv();
  endtask

  task automatic test_out_of_range();
    drv(0, 0, 0, 0, 1, 2'b00, 0, 32'h0BAD0000); adv();
    drv(0, 0, 0, 0, 1, 2'b00, 256, 32'hCAFEF00D);
    checks++; if (st_btk.n !== 1'b0) begin errors++; $display("FAIL oor_st_ack: got %b, required 0", st_btk.n); end
    adv();
    drv(1, 2'b00, 256, 0, 0, 0, 0, 0); exp_q.push_back(32'h0); adv();
    drv(1, 2'b00, 0, 0, 0, 0, 0, 0); exp_q.push_back(32'h0BAD0000);
    checks++;
    if (ld_data.v !== 1'b1 || ld_data.d !== 32'h0) begin
      errors++; $display("FAIL oor_ld: got v=%b d=%h, required v=1 d=0", ld_data.v, ld_data.d);
    end
    adv();
    drv(1, 2'b00, 1023, 0, 0, 0, 0, 0); exp_q.push_back(32'h0); adv();
    drv(0, 0, 0, 0, 0, 0, 0, 0); adv();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL oor_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_lanes();
    test_collision();
    test_back_to_back();
    test_overflow();
    test_out_of_range();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
